// File: rtl/bfloat16_fma_seq.sv
// rtl/bfloat16_fma_seq.sv - operand FIFO and issue sequencer chaining bfloat16 FMA results into dot products
// Optional FMA_SEQ_FLUSH_EN adds a flush input that abandons the current chain and queue.
module bfloat16_fma_seq #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
`ifdef FMA_SEQ_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [15:0]                wr_a,
  input  logic [15:0]                wr_b,
  input  logic                       wr_last,
  output logic                       fma_valid,
  input  logic                       fma_ready,
  output logic [15:0]                fma_a,
  output logic [15:0]                fma_b,
  output logic [15:0]                fma_c,
  input  logic                       fma_res_valid,
  input  logic [15:0]                fma_res,
  input  logic [4:0]                 fma_flags,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_data,
  output logic [4:0]                 res_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;
  logic [15:0]   acc;
  logic [4:0]    flags_q;
  logic          cur_last;
  logic          clr;
  logic          push, pop;
  logic [32:0]   head;

`ifdef FMA_SEQ_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign head     = mem[rd_ptr];
  assign wr_ready = (count_q != CW'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = fma_valid && fma_ready;
  assign count    = count_q;
  assign fma_a    = head[31:16];
  assign fma_b    = head[15:0];
  assign fma_c    = acc;
  assign res_data = acc;
  assign res_flags = flags_q;
  assign busy     = (state != IDLE) || (count_q != '0);

  always_ff @(posedge clk) begin
    if (!resetn || clr) state <= IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    fma_valid = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE:  if (count_q != '0) state_nx = ISSUE;
      ISSUE: begin
        fma_valid = 1'b1;
        if (fma_ready) state_nx = WAIT;
      end
      WAIT: begin
        // cur_last was captured at issue, so the chain end is known before the result lands
        if (fma_res_valid) begin
          if (cur_last)            state_nx = DONE;
          else if (count_q != '0)  state_nx = ISSUE;
          else                     state_nx = IDLE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      acc      <= '0;
      flags_q  <= '0;
      cur_last <= 1'b0;
      // Clearing storage keeps the operand outputs at zero after reset instead of stale data
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {wr_last, wr_a, wr_b};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_last <= head[32];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (state == WAIT && fma_res_valid) begin
        acc     <= fma_res;
        flags_q <= flags_q | fma_flags;
      end else if (state == DONE && res_ready) begin
        acc     <= '0;
        flags_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bfloat16_fma_seq.sv
// tb/tb_bfloat16_fma_seq.sv - directed self-checking bench for bfloat16_fma_seq
module tb_bfloat16_fma_seq;

  logic        clk = 1'b0;
  logic        resetn;
`ifdef FMA_SEQ_FLUSH_EN
  logic        flush;
`endif
  logic        wr_valid, wr_ready, wr_last;
  logic [15:0] wr_a, wr_b;
  logic        fma_valid, fma_ready;
  logic [15:0] fma_a, fma_b, fma_c;
  logic        fma_res_valid;
  logic [15:0] fma_res;
  logic [4:0]  fma_flags;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [4:0]  res_flags;
  logic [2:0]  count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bfloat16_fma_seq #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
`ifdef FMA_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_a(wr_a), .wr_b(wr_b), .wr_last(wr_last),
    .fma_valid(fma_valid), .fma_ready(fma_ready), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_res_valid(fma_res_valid), .fma_res(fma_res), .fma_flags(fma_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
    .count(count), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic last);
    wr_valid = 1'b1; wr_a = a; wr_b = b; wr_last = last;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
    for (int i = 0; i < 20 && !fma_valid; i++) tick();
    chk({tag, "_valid"}, fma_valid, 1);
    chk({tag, "_a"}, fma_a, ea);
    chk({tag, "_b"}, fma_b, eb);
    chk({tag, "_c"}, fma_c, ec);
    fma_ready = 1'b1;
    tick();
    fma_ready = 1'b0;
  endtask

  // Latency 3: handshake at edge h, result sampled at edge h+3
  task automatic respond(input logic [15:0] r, input logic [4:0] f);
    tick();
    tick();
    fma_res_valid = 1'b1; fma_res = r; fma_flags = f;
    tick();
    fma_res_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    chk({tag, "_res_valid"}, res_valid, 1);
  endtask

  initial begin
    resetn = 1'b0;
`ifdef FMA_SEQ_FLUSH_EN
    flush = 1'b0;
`endif
    wr_valid = 0; wr_a = 0; wr_b = 0; wr_last = 0;
    fma_ready = 0; fma_res_valid = 0; fma_res = 0; fma_flags = 0; res_ready = 0;
    tick();
    tick();
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_fma_valid", fma_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_fma_abc", {fma_a, fma_b}, 0);
    chk("rst_fma_c", fma_c, 0);
    resetn = 1'b1;
    tick();

    // Dot product 1*2 + 2*3 = 8.0
    push(16'h3F80, 16'h4000, 1'b0);
    chk("dp_count1", count, 1);
    chk("dp_valid_early", fma_valid, 0);
    push(16'h4000, 16'h4040, 1'b1);
    chk("dp_count2", count, 2);
    chk("dp_valid_t2", fma_valid, 1);
    issue("dp_i0", 16'h3F80, 16'h4000, 16'h0000);
    respond(16'h4000, 5'b0);
    chk("dp_reissue_r1", fma_valid, 1);
    issue("dp_i1", 16'h4000, 16'h4040, 16'h4000);
    respond(16'h4100, 5'b0);
    chk("dp_res_r1", res_valid, 1);
    wait_res("dp");
    chk("dp_res_data", res_data, 16'h4100);
    chk("dp_res_flags", res_flags, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("dp_res_clear", res_valid, 0);
    chk("dp_acc_clear", res_data, 0);
    chk("dp_idle", busy, 0);

    // Full FIFO, simultaneous pop/push while full, and pointer wrap
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_a = 16'h1000 + 16'(i); wr_b = 16'h2000 + 16'(i); wr_last = 1'b0;
      chk($sformatf("full_wr_ready%0d", i), wr_ready, (i < 4) ? 1 : 0);
      tick();
    end
    chk("full_count", count, 4);
    chk("full_wr_ready", wr_ready, 0);
    wr_a = 16'h1005; wr_b = 16'h2005;
    fma_ready = 1'b1;
    chk("full_pop_valid", fma_valid, 1);
    chk("full_pop_a", fma_a, 16'h1000);
    tick();
    fma_ready = 1'b0;
    wr_valid = 1'b0;
    chk("full_no_push", count, 3);
    push(16'h1004, 16'h2004, 1'b1);
    chk("wrap_count", count, 4);
    tick();
    fma_res_valid = 1'b1; fma_res = 16'h1111; fma_flags = 0;
    tick();
    fma_res_valid = 1'b0;
    issue("wrap_i1", 16'h1001, 16'h2001, 16'h1111);
    respond(16'h2222, 5'b0);
    issue("wrap_i2", 16'h1002, 16'h2002, 16'h2222);
    respond(16'h3333, 5'b0);
    issue("wrap_i3", 16'h1003, 16'h2003, 16'h3333);
    respond(16'h4444, 5'b0);
    issue("wrap_i4", 16'h1004, 16'h2004, 16'h4444);
    respond(16'h5555, 5'b0);
    wait_res("wrap");
    chk("wrap_res_data", res_data, 16'h5555);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Sticky flags over a 3-element chain
    push(16'h3F80, 16'h3F80, 1'b0);
    push(16'h3F80, 16'h3F80, 1'b0);
    push(16'h4000, 16'h4000, 1'b1);
    issue("stk_i0", 16'h3F80, 16'h3F80, 16'h0000);
    respond(16'h3F80, 5'b00001);
    issue("stk_i1", 16'h3F80, 16'h3F80, 16'h3F80);
    respond(16'h4000, 5'b00100);
    issue("stk_i2", 16'h4000, 16'h4000, 16'h4000);
    respond(16'h40C0, 5'b00000);
    wait_res("stk");
    chk("stk_res_data", res_data, 16'h40C0);
    chk("stk_res_flags", res_flags, 5'b00101);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("stk_acc_clear", res_data, 0);
    chk("stk_flags_clear", res_flags, 0);
    chk("stk_fma_c_clear", fma_c, 0);

    // Stray result in IDLE with a non-zero partial accumulator
    push(16'h3F80, 16'h3F80, 1'b0);
    issue("str_i0", 16'h3F80, 16'h3F80, 16'h0000);
    respond(16'h3F80, 5'b0);
    tick();
    chk("str_idle", busy, 0);
    fma_res_valid = 1'b1; fma_res = 16'h7777; fma_flags = 5'b11111;
    tick();
    fma_res_valid = 1'b0;
    chk("str_acc_kept", fma_c, 16'h3F80);
    chk("str_flags_kept", res_flags, 0);
    chk("str_busy", busy, 0);
    push(16'h4000, 16'h4000, 1'b1);
    issue("str_i1", 16'h4000, 16'h4000, 16'h3F80);
    respond(16'h40A0, 5'b0);
    wait_res("str");
    chk("str_res_data", res_data, 16'h40A0);
    chk("str_res_flags", res_flags, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset while waiting for a result
    push(16'h3F80, 16'h4000, 1'b0);
    push(16'h4000, 16'h4000, 1'b0);
    push(16'h4040, 16'h4040, 1'b1);
    issue("mrst_i0", 16'h3F80, 16'h4000, 16'h0000);
    chk("mrst_count", count, 2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    fma_res_valid = 1'b1; fma_res = 16'h4000; fma_flags = 5'b00001;
    tick();
    fma_res_valid = 1'b0;
    tick();
    chk("mrst_count0", count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fma_valid", fma_valid, 0);
    chk("mrst_acc", fma_c, 0);
    chk("mrst_flags", res_flags, 0);
    chk("mrst_res_valid", res_valid, 0);

`ifdef FMA_SEQ_FLUSH_EN
    push(16'h3F80, 16'h4000, 1'b0);
    push(16'h4000, 16'h4000, 1'b0);
    push(16'h4040, 16'h4040, 1'b1);
    issue("fl_i0", 16'h3F80, 16'h4000, 16'h0000);
    chk("fl_count_pre", count, 2);
    flush = 1'b1;
    wr_valid = 1'b1; wr_a = 16'h1234; wr_b = 16'h5678; wr_last = 1'b1;
    tick();
    flush = 1'b0;
    wr_valid = 1'b0;
    chk("fl_count0", count, 0);
    chk("fl_busy", busy, 0);
    fma_res_valid = 1'b1; fma_res = 16'h4000; fma_flags = 5'b00010;
    tick();
    fma_res_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fl_no_res%0d", i), res_valid, 0);
      tick();
    end
    chk("fl_acc", fma_c, 0);
    chk("fl_flags", res_flags, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bfloat16_fma_seq.md
# bfloat16_fma_seq

Issue sequencer that sits directly upstream of the bfloat16 FMA core and chains its results into dot products. Buffers (a, b) operand pairs in a small FIFO, issues them one at a time as a*b + c, and feeds each result back as the next c. Each dot product ends at an element tagged `last`. The accumulated value and sticky exception flags are presented on a result handshake.

## Interface
- `DEPTH`, 4: operand FIFO entries; must be a power of 2, minimum 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `wr_valid` in 1: operand pair offered.
- `wr_ready` out 1: FIFO not full.
- `wr_a`, `wr_b` in 16 each: bfloat16 multiplicands.
- `wr_last` in 1: pair is the final element of the current dot product.
- `fma_valid` out 1: issue request to the FMA.
- `fma_ready` in 1: FMA accepts the issue.
- `fma_a`, `fma_b`, `fma_c` out 16 each: issued operands.
- `fma_res_valid` in 1: FMA result strobe, one cycle.
- `fma_res` in 16: result value.
- `fma_flags` in 5: per-op exception flags {invalid, infinite, overflow, underflow, inexact}.
- `res_valid` out 1: dot-product result available.
- `res_ready` in 1: consumer takes result.
- `res_data` out 16: accumulated result.
- `res_flags` out 5: OR of `fma_flags` over the chain.
- `count` out clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: state != IDLE or count != 0.

## Operation
- FIFO entry = {last, a, b}, 33 bits.
  - Push when `wr_valid && wr_ready`.
  - Pop on the issue handshake.
  - Pointers wrap modulo DEPTH.
- `wr_ready` = (count != DEPTH). It is derived from the current count, so a push while full is refused even if a pop occurs that cycle.
- Registers:
  - acc (16): reset 16'h0000 (+0.0).
  - flags (5): reset 0.
  - cur_last (1).
- FSM states IDLE, ISSUE, WAIT, DONE; reset state is IDLE.
  - IDLE: count != 0 -> ISSUE.
  - ISSUE: `fma_valid`=1; `fma_a`/`fma_b` = FIFO head; `fma_c` = acc. On `fma_ready`: pop, cur_last <= head.last, -> WAIT.
  - WAIT: `fma_res_valid` -> acc <= `fma_res`, flags <= flags | `fma_flags`. Next state: DONE if cur_last; else ISSUE if count != 0; else IDLE.
  - DONE: `res_valid`=1, `res_data`=acc, `res_flags`=flags. On `res_ready`: acc <= 0, flags <= 0, -> IDLE.
- `fma_res_valid` outside WAIT is ignored; no state change.
- Pushes are accepted in every state, including DONE, so the next chain queues behind the pending result.
- Operand outputs are don't-care outside ISSUE but are driven from the head and acc, never X.
- Reset mid-operation:
  - State -> IDLE; FIFO emptied; acc and flags cleared.
  - A late FMA result is discarded (not in WAIT).

## Timing
- Reset values:
  - `fma_valid`, `res_valid`, `busy` = 0.
  - `wr_ready` = 1; `count` = 0.
  - `res_data`, `res_flags` = 0.
  - `fma_a`/`fma_b`/`fma_c` = 0.
- Push accepted at edge t:
  - count updates at t+1.
  - IDLE -> ISSUE at t+2, so `fma_valid` first high in cycle t+2.
- `fma_valid` stays high and operands stay stable until `fma_ready`; there is no withdrawal.
- Result at edge r:
  - acc updates at r+1.
  - The next issue (non-last, FIFO non-empty) has `fma_valid` high in cycle r+1 with `fma_c` = new acc.
- `res_valid` is high from the cycle after the last result until the `res_ready` handshake.
- At most one FMA operation is in flight; the FMA latency is arbitrary (≥1 cycle).

## Configuration
- `FMA_SEQ_FLUSH_EN` defined: adds input `flush` (1).
  - When high at an edge, takes effect regardless of state, including while in WAIT.
  - Empties the FIFO, clears acc and flags, and goes to IDLE.
  - A result arriving after the flush is ignored.
  - `flush` has priority over a simultaneous push, which is dropped.
  - `resetn` low overrides `flush`.
- Not defined: no `flush` port; a chain can only be abandoned via `resetn`.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles -> `wr_ready`=1, `count`=0, `fma_valid`=0, `res_valid`=0, `busy`=0.
- Dot product with an FMA model of latency 3:
  - Stimulus: push (3F80,4000,last=0) then (4000,4040,last=1).
  - Required issues: (3F80,4000,c=0000), then (4000,4040,c=4000).
  - Required result: `res_data`=4100 (8.0), `res_flags`=0.
- Full and back-pressure:
  - Stimulus: `fma_ready`=0, push 5 pairs.
  - Required: 4 accepted, `wr_ready`=0 at count=4; a pop/push in the same cycle while full accepts no push.
  - Then FIFO order is preserved across pointer wrap.
- Sticky flags:
  - Stimulus: 3-element chain with the model returning flags 00001, 00100, 00000.
  - Required: `res_flags`=00101; acc and flags are 0 after the `res_ready` handshake.
- Stray result and mid-chain reset:
  - `fma_res_valid` pulsed in IDLE -> acc unchanged.
  - `resetn`=0 while in WAIT -> FIFO empty, late result ignored.
- `FMA_SEQ_FLUSH_EN`: `flush` in WAIT with 2 entries queued -> count=0, IDLE, the following result discarded, `res_valid` never asserted.
